// File: rtl/qq_cmd_front.sv
// Host command front-end for the QuickQ node controller: buffers ENQ/DEQ/REPL
// commands, issues them one at a time as strobes and returns one response each.
module qq_cmd_front #(
  parameter int W   = 32,
  parameter int VW  = 32,
  parameter int CAP = 4,
  parameter int FD  = 4,
  localparam int KVW = W + VW,
  localparam int CW  = $clog2(CAP + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [KVW-1:0] cmd_kv,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [KVW-1:0] resp_kv,
  output logic           resp_err,
  input  logic           q_rdy,
  output logic           q_enq,
  output logic           q_deq,
  output logic           q_repl,
  output logic [KVW-1:0] q_data,
  input  logic [KVW-1:0] q_top,
  output logic [CW-1:0]  count
);
  localparam int AW = $clog2(FD);
  localparam logic [1:0] OP_ENQ  = 2'b01;
  localparam logic [1:0] OP_DEQ  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_BUSY, S_RESP} state_e;
  state_e state_q, state_d;

  // kv_t layout: key in the upper W bits, value in the lower VW bits
  logic [KVW+1:0] mem_q [FD];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic           empty, full, push, pop;
  logic [1:0]     op_q, op_d, head_op;
  logic [KVW-1:0] kv_q, kv_d, head_kv, rkv_q, rkv_d;
  logic           rerr_q, rerr_d, head_err;
  logic [CW-1:0]  count_q, count_d;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign {head_op, head_kv} = mem_q[rd_ptr_q[AW-1:0]];

  assign head_err = (head_op == 2'b00) ||
                    (head_op == OP_ENQ && count_q == CW'(CAP)) ||
                    (head_op != OP_ENQ && count_q == '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_kv};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      op_q     <= '0;
      kv_q     <= '0;
      rkv_q    <= '0;
      rerr_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      op_q     <= op_d;
      kv_q     <= kv_d;
      rkv_q    <= rkv_d;
      rerr_q   <= rerr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    kv_d    = kv_q;
    rkv_d   = rkv_q;
    rerr_d  = rerr_q;
    count_d = count_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && q_rdy) begin
          pop  = 1'b1;
          op_d = head_op;
          kv_d = head_kv;
          if (head_err) begin
            rkv_d   = {{W{1'b1}}, {VW{1'b0}}};
            rerr_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        rerr_d = 1'b0;
        rkv_d  = (op_q == OP_ENQ) ? kv_q : q_top;
        if (op_q == OP_ENQ)      count_d = count_q + CW'(1);
        else if (op_q == OP_DEQ) count_d = count_q - CW'(1);
        state_d = S_GUARD;
      end
      // queue still shows rdy in the cycle right after the strobe
      S_GUARD: state_d = S_BUSY;
      S_BUSY:  if (q_rdy) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_valid = (state_q == S_RESP);
  assign resp_kv    = rkv_q;
  assign resp_err   = rerr_q;
  assign q_enq      = (state_q == S_ISSUE) && (op_q == OP_ENQ);
  assign q_deq      = (state_q == S_ISSUE) && (op_q == OP_DEQ);
  assign q_repl     = (state_q == S_ISSUE) && (op_q == OP_REPL);
  assign q_data     = (state_q == S_ISSUE) ? kv_q : '0;
  assign count      = count_q;

endmodule

// File: tb/tb_qq_cmd_front.sv
// Scoreboard bench for qq_cmd_front: a min-priority queue emulates the node
// chain downstream, and an abstract reference queue predicts every response.
module tb_qq_cmd_front;
  localparam int W = 32, VW = 32, CAP = 4, FD = 4, KVW = 64, CW = 3;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, resp_valid, resp_ready, resp_err;
  logic q_rdy = 1'b1;
  logic q_enq, q_deq, q_repl;
  logic [1:0] cmd_op;
  logic [KVW-1:0] cmd_kv, resp_kv, q_data;
  logic [KVW-1:0] q_top = '0;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  qq_cmd_front #(.W(W), .VW(VW), .CAP(CAP), .FD(FD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_kv(cmd_kv), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_kv(resp_kv), .resp_err(resp_err),
    .q_rdy(q_rdy), .q_enq(q_enq), .q_deq(q_deq), .q_repl(q_repl),
    .q_data(q_data), .q_top(q_top), .count(count)
  );

  int checks = 0, passes = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int qmin(input logic [63:0] q[$]);
    int m = 0;
    for (int i = 1; i < q.size(); i++) if (q[i][63:32] < q[m][63:32]) m = i;
    return m;
  endfunction

  // downstream queue emulation: rdy stays high one cycle after a strobe,
  // then drops for a random number of cycles
  logic [63:0] dq[$];
  int busy = 0, busy_min = 1, busy_max = 4;
  bit pend = 0;
  logic s_enq = 0, s_deq = 0, s_repl = 0;
  logic [63:0] s_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      dq.delete(); busy = 0; pend = 0;
    end else begin
      if (busy > 0) busy--;
      if (pend) begin pend = 0; busy = $urandom_range(busy_min, busy_max); end
      if (s_enq) dq.push_back(s_data);
      else if (s_deq) begin if (dq.size() > 0) dq.delete(qmin(dq)); end
      else if (s_repl) begin
        if (dq.size() > 0) dq.delete(qmin(dq));
        dq.push_back(s_data);
      end
      if (s_enq || s_deq || s_repl) pend = 1;
    end
  end

  always @(negedge clk) begin
    s_enq = q_enq; s_deq = q_deq; s_repl = q_repl; s_data = q_data;
    q_rdy = (busy == 0);
    q_top = (dq.size() > 0) ? dq[qmin(dq)] : '0;
  end

  // reference model: abstract min-queue with capacity CAP
  typedef struct {
    logic [63:0] kv;
    logic [63:0] qd;
    logic        err;
    int          cnt;
    logic [1:0]  op;
  } exp_t;
  exp_t expq[$];
  logic [63:0] rm[$];

  function automatic exp_t ref_apply(input logic [1:0] op, input logic [63:0] kv);
    exp_t e;
    int m;
    e.op = op; e.qd = kv; e.err = 0; e.kv = kv;
    if (op == 2'b01 && rm.size() < CAP) rm.push_back(kv);
    else if (op == 2'b10 && rm.size() > 0) begin
      m = qmin(rm); e.kv = rm[m]; rm.delete(m);
    end else if (op == 2'b11 && rm.size() > 0) begin
      m = qmin(rm); e.kv = rm[m]; rm.delete(m); rm.push_back(kv);
    end else e.err = 1;
    if (e.err) e.kv = {32'hFFFF_FFFF, 32'h0};
    e.cnt = rm.size();
    return e;
  endfunction

  // strobe observer
  int n_stb = 0, tot_stb = 0;
  logic [1:0] stb_op = '0;
  logic [63:0] stb_data = '0;
  always @(negedge clk) if (!rst) begin
    if (q_enq || q_deq || q_repl) begin
      chk("strobe_onehot", 64'(int'(q_enq) + int'(q_deq) + int'(q_repl)), 64'd1);
      n_stb++; tot_stb++;
      stb_op = q_enq ? 2'b01 : (q_deq ? 2'b10 : 2'b11);
      stb_data = q_data;
    end else chk("qdata_idle", q_data, 64'd0);
  end

  // response monitor
  always @(negedge clk) begin
    if (rst) n_stb = 0;
    else if (resp_valid && resp_ready) begin
      if (expq.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = expq.pop_front();
        chk("resp_kv", resp_kv, e.kv);
        chk("resp_err", 64'(resp_err), 64'(e.err));
        chk("count", 64'(count), 64'(e.cnt));
        chk("n_strobes", 64'(n_stb), e.err ? 64'd0 : 64'd1);
        if (!e.err) begin
          chk("strobe_op", 64'(stb_op), 64'(e.op));
          chk("strobe_data", stb_data, e.qd);
        end
      end
      n_stb = 0;
    end
  end

  task automatic send(input logic [1:0] op, input logic [63:0] kv);
    int n = 0;
    cmd_valid = 1; cmd_op = op; cmd_kv = kv;
    while (1) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 1000) begin
        chk("cmd_ready_timeout", 64'd0, 64'd1);
        cmd_valid = 0;
        return;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    expq.push_back(ref_apply(op, kv));
    #1;
    cmd_valid = 0; cmd_op = '0; cmd_kv = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 3000) begin @(negedge clk); n++; end
    chk("drain_done", 64'(expq.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] k(input int key);
    return {32'(key), 32'(key) ^ 32'h5A5A_0000};
  endfunction

  bit sdone = 0;
  int s0;

  initial begin
    rst = 1; cmd_valid = 0; cmd_op = '0; cmd_kv = '0; resp_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_strobes", 64'({q_enq, q_deq, q_repl}), 64'd0);
    chk("rst_q_data", q_data, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_resp_kv", resp_kv, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    // ENQ 5: strobe exactly one cycle, two cycles after the push
    send(2'b01, k(5));
    @(negedge clk); chk("enq_t1_no_strobe", 64'(q_enq), 64'd0);
    @(negedge clk); chk("enq_t2_strobe", 64'(q_enq), 64'd1);
    chk("enq_t2_key", 64'(q_data[63:32]), 64'd5);
    @(negedge clk); chk("enq_t3_no_strobe", 64'(q_enq), 64'd0);
    drain();
    chk("count_after_enq5", 64'(count), 64'd1);

    send(2'b10, '0);
    send(2'b01, k(9)); send(2'b01, k(3)); send(2'b01, k(7));
    send(2'b10, '0); send(2'b10, '0); send(2'b10, '0);
    drain();
    chk("count_empty", 64'(count), 64'd0);

    // DEQ on empty: error response two cycles after push, no strobe
    s0 = tot_stb;
    send(2'b10, '0);
    @(negedge clk); chk("err_t1_valid", 64'(resp_valid), 64'd0);
    @(negedge clk); chk("err_t2_valid", 64'(resp_valid), 64'd1);
    chk("err_t2_key", 64'(resp_kv[63:32]), 64'hFFFF_FFFF);
    drain();
    chk("err_no_strobe", 64'(tot_stb - s0), 64'd0);

    // fill to CAP, overflow, replace
    send(2'b01, k(50)); send(2'b01, k(60)); send(2'b01, k(40)); send(2'b01, k(70));
    send(2'b01, k(1));
    send(2'b11, k(2));
    drain();
    chk("count_full", 64'(count), 64'd4);
    repeat (4) send(2'b10, '0);
    drain();

    // response stall: FIFO fills behind the in-flight command
    resp_ready = 0;
    s0 = tot_stb;
    send(2'b01, k(40)); send(2'b01, k(20)); send(2'b11, k(30));
    send(2'b10, '0); send(2'b01, k(10));
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("stall_resp_valid", 64'(resp_valid), 64'd1);
    chk("stall_one_strobe", 64'(tot_stb - s0), 64'd1);
    @(posedge clk); #1;
    fork
      send(2'b10, '0);
      begin repeat (3) @(posedge clk); #1 resp_ready = 1; end
    join
    drain();
    chk("stall_all_strobes", 64'(tot_stb - s0), 64'd6);
    while (count != 0) begin send(2'b10, '0); drain(); end

    // reset while BUSY with two commands queued
    busy_min = 30; busy_max = 30;
    send(2'b01, k(100)); send(2'b01, k(200)); send(2'b01, k(300));
    s0 = 0;
    while (q_rdy && s0 < 50) begin @(negedge clk); s0++; end
    chk("reached_busy", 64'(q_rdy), 64'd0);
    @(posedge clk); #1 rst = 1;
    expq.delete(); rm.delete();
    busy_min = 1; busy_max = 4;
    @(negedge clk); chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_strobes", 64'({q_enq, q_deq, q_repl}), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_resp_kv", resp_kv, 64'd0);
    chk("midrst_resp_err", 64'(resp_err), 64'd0);
    s0 = tot_stb;
    repeat (10) @(negedge clk);
    chk("midrst_no_strobes", 64'(tot_stb - s0), 64'd0);
    @(posedge clk); #1;
    send(2'b01, k(77));
    drain();

    // randomized traffic with random response back-pressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int r;
          logic [1:0] op;
          r = $urandom_range(0, 9);
          op = (r == 0) ? 2'b00 : (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
          send(op, {32'($urandom), 32'($urandom)});
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
          #0;
        end
        sdone = 1;
      end
      begin
        while (!sdone) begin
          @(posedge clk); #1 resp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    resp_ready = 1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
